// File: rtl/fifo_read_packer.sv
// Read-side drain for an asynchronous FIFO: pops entries, packs PACK_COUNT of them per output word,
// and emits partial words with a keep mask on flush or idle timeout.
module fifo_read_packer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PACK_COUNT   = 4,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                             recv_clk_i,
  input  logic                             recv_rst_ni,
  input  logic                             fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]            recv_data_i,
  output logic                             read_enable_o,
  input  logic                             flush_i,
  output logic [DATA_WIDTH*PACK_COUNT-1:0] out_data_o,
  output logic [PACK_COUNT-1:0]            out_keep_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i
);

  localparam int unsigned CntW = $clog2(PACK_COUNT + 1);
  localparam int unsigned TmrW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(PACK_COUNT);
  localparam logic [TmrW-1:0] TmrMax  = TmrW'(IDLE_TIMEOUT);
  localparam logic [CntW:0]   OccFull = (CntW + 1)'(PACK_COUNT);

  typedef enum logic [0:0] {StCollect, StHold} state_e;
  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]            lane_q [PACK_COUNT];
  logic [DATA_WIDTH-1:0]            lane_d [PACK_COUNT];
  logic [CntW-1:0]                  count_q, count_d;
  logic                             in_flight_q, in_flight_d;
  logic [TmrW-1:0]                  timer_q, timer_d;
  logic                             flush_pend_q, flush_pend_d;
  logic                             read_ok_q, read_ok_d;
  logic [DATA_WIDTH*PACK_COUNT-1:0] out_data_q, out_data_d;
  logic [PACK_COUNT-1:0]            out_keep_q, out_keep_d;
  logic                             out_valid_q, out_valid_d;

  logic            out_free, word_full, timed_out, emit_partial, transfer, pop;
  logic            timed_out_d, emit_pend_d;
  logic [CntW:0]   occupancy_d;

  always_ff @(posedge recv_clk_i or negedge recv_rst_ni) begin
    if (!recv_rst_ni) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (count_q == CntFull && !out_free) state_d = StHold;
      StHold:    if (out_free) state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  always_comb begin
    out_free     = !out_valid_q || out_ready_i;
    word_full    = (state_q == StHold) || (count_q == CntFull);
    timed_out    = (IDLE_TIMEOUT > 0) && (timer_q == TmrMax);
    emit_partial = (count_q != '0) && !in_flight_q && (flush_pend_q || timed_out);
    transfer     = out_free && (word_full || emit_partial);
    // The registered qualifier already excludes full/flush/timeout; only emptiness is live.
    pop          = read_ok_q && !fifo_empty_i;
  end

  always_comb begin
    lane_d       = lane_q;
    count_d      = count_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q;
    flush_pend_d = flush_pend_q;
    timer_d      = timer_q;
    in_flight_d  = pop;

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    if (transfer) begin
      for (int i = 0; i < PACK_COUNT; i++) begin
        out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_q[i];
        out_keep_d[i] = CntW'(i) < count_q;
        lane_d[i]     = '0;
      end
      out_valid_d  = 1'b1;
      count_d      = '0;
      flush_pend_d = 1'b0;
    end else if (in_flight_q) begin
      for (int i = 0; i < PACK_COUNT; i++) begin
        if (CntW'(i) == count_q) lane_d[i] = recv_data_i;
      end
      count_d = count_q + 1'b1;
    end

    // A flush that coincides with the word filling up just yields a normal full word.
    if (!transfer && flush_i && (count_q != '0 || in_flight_q) && count_d != CntFull) begin
      flush_pend_d = 1'b1;
    end

    if (transfer || in_flight_q || count_q == '0) begin
      timer_d = '0;
    end else if (timer_q != TmrMax) begin
      timer_d = timer_q + 1'b1;
    end

    occupancy_d = {1'b0, count_d} + {{CntW{1'b0}}, in_flight_d};
    timed_out_d = (IDLE_TIMEOUT > 0) && (timer_d == TmrMax);
    emit_pend_d = (count_d != '0) && !in_flight_d && (flush_pend_d || timed_out_d);
    read_ok_d   = (occupancy_d < OccFull) && !flush_pend_d && !emit_pend_d;
  end

  always_ff @(posedge recv_clk_i or negedge recv_rst_ni) begin
    if (!recv_rst_ni) begin
      for (int i = 0; i < PACK_COUNT; i++) lane_q[i] <= '0;
      count_q      <= '0;
      in_flight_q  <= 1'b0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
      read_ok_q    <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      count_q      <= count_d;
      in_flight_q  <= in_flight_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
      read_ok_q    <= read_ok_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign read_enable_o = pop;
  assign out_data_o    = out_data_q;
  assign out_keep_o    = out_keep_q;
  assign out_valid_o   = out_valid_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: FIFO model, in-order word scoreboard, directed vectors and random run.
module tb_fifo_read_packer;

  localparam int Timeout = 16;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  recv_data;
  logic        read_enable;
  logic        flush;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;

  fifo_read_packer #(
    .DATA_WIDTH  (8),
    .PACK_COUNT  (4),
    .IDLE_TIMEOUT(Timeout)
  ) dut (
    .recv_clk_i   (clk),
    .recv_rst_ni  (rst_n),
    .fifo_empty_i (fifo_empty),
    .recv_data_i  (recv_data),
    .read_enable_o(read_enable),
    .flush_i      (flush),
    .out_data_o   (out_data),
    .out_keep_o   (out_keep),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];
  int          fifo_sz = 0;
  logic        gap = 1'b0;
  logic        pop_now = 1'b0;
  int          cyc = 0;
  int          last_pop_cyc = 0;
  int          first_valid_cyc = 0;
  logic        hold_prev = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_keep = '0;

  always @* fifo_empty = gap || (fifo_sz == 0);

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // FIFO model: a pop granted in one cycle presents its data for capture on the next edge.
  always @(posedge clk) begin
    cyc++;
    if (pop_now && fifo_q.size() > 0) begin
      recv_data <= fifo_q[0];
      exp_q.push_back(fifo_q.pop_front());
      fifo_sz <= fifo_sz - 1;
      last_pop_cyc = cyc;
    end
    if (!rst_n) exp_q.delete();
  end

  // Monitor: every accepted word must equal the next popped entries, lane 0 first.
  always @(negedge clk) begin
    int          k;
    logic [3:0]  kexp;
    logic [31:0] ew;
    bit          ok;
    if (!rst_n) begin
      hold_prev  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (fifo_empty) chk(read_enable == 1'b0, "read_while_empty", 32'(read_enable), 32'h0);
      if (hold_prev) begin
        chk(out_valid && out_data == prev_data && out_keep == prev_keep, "hold_stable",
            out_data, prev_data);
      end
      if (out_valid && !prev_valid) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        k    = $countones(out_keep);
        kexp = 4'((1 << k) - 1);
        ok   = (k > 0) && (exp_q.size() >= k);
        ew   = '0;
        for (int i = 0; i < k; i++) begin
          if (exp_q.size() > 0) ew[i*8 +: 8] = exp_q.pop_front();
        end
        chk(ok && out_keep == kexp, "word_keep", 32'(out_keep), 32'(kexp));
        chk(out_data == ew, "word_data", out_data, ew);
        got_data.push_back(out_data);
        got_keep.push_back(out_keep);
      end
      hold_prev  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_keep  = out_keep;
      prev_valid = out_valid;
    end
    pop_now = read_enable && !fifo_empty;
  end

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    fifo_sz = fifo_sz + 1;
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_got();
    got_data.delete();
    got_keep.delete();
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int i = 0;
    while (got_data.size() < n && i < budget) begin
      cyc_wait(1);
      i++;
    end
    chk(got_data.size() >= n, name, 32'(got_data.size()), 32'(n));
  endtask

  typedef struct {
    int          n;
    logic [7:0]  base;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int i;
    vecs[0] = '{n: 1, base: 8'h41, exp_data: 32'h0000_0041, exp_keep: 4'b0001};
    vecs[1] = '{n: 2, base: 8'h31, exp_data: 32'h0000_3231, exp_keep: 4'b0011};
    vecs[2] = '{n: 3, base: 8'h51, exp_data: 32'h0053_5251, exp_keep: 4'b0111};
    vecs[3] = '{n: 4, base: 8'h61, exp_data: 32'h6463_6261, exp_keep: 4'b1111};

    // Reset with pending data and flush: everything stays 0.
    rst_n     = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    recv_data = '0;
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    repeat (5) begin
      @(negedge clk);
      chk(read_enable == 1'b0, "rst_read_enable", 32'(read_enable), 32'h0);
      chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'h0);
      chk(out_keep == 4'h0, "rst_out_keep", 32'(out_keep), 32'h0);
      chk(out_data == 32'h0, "rst_out_data", out_data, 32'h0);
    end
    fifo_q.delete();
    fifo_sz = 0;
    flush   = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc_wait(2);

    // Two full words streaming through.
    clear_got();
    for (int v = 'h11; v <= 'h18; v++) push(8'(v));
    wait_words(2, 60, "stream_words");
    chk(got_data[0] == 32'h1413_1211 && got_keep[0] == 4'hF, "stream_w0", got_data[0],
        32'h1413_1211);
    chk(got_data[1] == 32'h1817_1615 && got_keep[1] == 4'hF, "stream_w1", got_data[1],
        32'h1817_1615);
    cyc_wait(30);
    chk(got_data.size() == 2, "stream_no_extra", 32'(got_data.size()), 32'd2);

    // Backpressure: one word held, a second collected, reads stall.
    clear_got();
    out_ready = 1'b0;
    for (int v = 'h11; v <= 'h1C; v++) push(8'(v));
    cyc_wait(20);
    chk(out_valid == 1'b1, "bp_valid", 32'(out_valid), 32'h1);
    chk(out_data == 32'h1413_1211, "bp_data", out_data, 32'h1413_1211);
    chk(out_keep == 4'hF, "bp_keep", 32'(out_keep), 32'hF);
    chk(fifo_sz == 4, "bp_fifo_left", 32'(fifo_sz), 32'd4);
    repeat (4) begin
      @(negedge clk);
      chk(read_enable == 1'b0, "bp_read_stall", 32'(read_enable), 32'h0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_words(3, 40, "bp_words");
    chk(got_data[0] == 32'h1413_1211, "bp_w0", got_data[0], 32'h1413_1211);
    chk(got_data[1] == 32'h1817_1615, "bp_w1", got_data[1], 32'h1817_1615);
    chk(got_data[2] == 32'h1C1B_1A19, "bp_w2", got_data[2], 32'h1C1B_1A19);
    cyc_wait(5);

    // Idle timeout: pop at P, capture at P+1, timer reaches the limit, word appears next edge.
    clear_got();
    push(8'h21);
    push(8'h22);
    push(8'h23);
    wait_words(1, 40, "timeout_word");
    chk(got_data[0] == 32'h0023_2221, "timeout_data", got_data[0], 32'h0023_2221);
    chk(got_keep[0] == 4'b0111, "timeout_keep", 32'(got_keep[0]), 32'h7);
    chk(first_valid_cyc == last_pop_cyc + Timeout + 2, "timeout_latency",
        32'(first_valid_cyc - last_pop_cyc), 32'(Timeout + 2));
    cyc_wait(5);

    // Flush vectors; the four-entry row fills before the flush, which is then ignored.
    foreach (vecs[r]) begin
      clear_got();
      for (int j = 0; j < vecs[r].n; j++) push(vecs[r].base + 8'(j));
      cyc_wait(vecs[r].n + 4);
      flush = 1'b1;
      cyc_wait(1);
      flush = 1'b0;
      wait_words(1, 10, "vec_word");
      chk(got_data[0] == vecs[r].exp_data, "vec_data", got_data[0], vecs[r].exp_data);
      chk(got_keep[0] == vecs[r].exp_keep, "vec_keep", 32'(got_keep[0]), 32'(vecs[r].exp_keep));
      cyc_wait(25);
      chk(got_data.size() == 1, "vec_no_extra", 32'(got_data.size()), 32'd1);
    end

    // Flush while the only entry is still in flight.
    clear_got();
    push(8'h71);
    i = 0;
    while (!read_enable && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk(read_enable == 1'b1, "inflight_read", 32'(read_enable), 32'h1);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    wait_words(1, 6, "inflight_word");
    chk(got_data[0] == 32'h0000_0071, "inflight_data", got_data[0], 32'h0000_0071);
    chk(got_keep[0] == 4'b0001, "inflight_keep", 32'(got_keep[0]), 32'h1);
    cyc_wait(5);

    // Random gaps, backpressure, flushes and a reset pulse.
    clear_got();
    for (int c = 0; c < 200; c++) begin
      gap       = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      if (fifo_sz < 4) push(8'($urandom));
      if (c == 100) rst_n = 1'b0;
      if (c == 102) rst_n = 1'b1;
      cyc_wait(1);
    end
    gap       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    i = 0;
    while (!(exp_q.size() == 0 && fifo_sz == 0 && !out_valid) && i < 300) begin
      cyc_wait(1);
      i++;
    end
    chk(exp_q.size() == 0 && fifo_sz == 0, "random_drain", 32'(exp_q.size()), 32'h0);

    // Reset mid-word: the partial word is dropped and packing restarts at lane 0.
    clear_got();
    push(8'h81);
    push(8'h82);
    cyc_wait(6);
    rst_n = 1'b0;
    cyc_wait(2);
    chk(out_valid == 1'b0, "midrst_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    for (int v = 'h91; v <= 'h94; v++) push(8'(v));
    wait_words(1, 20, "midrst_word");
    chk(got_data[0] == 32'h9493_9291, "midrst_data", got_data[0], 32'h9493_9291);
    chk(got_keep[0] == 4'hF, "midrst_keep", 32'(got_keep[0]), 32'hF);
    cyc_wait(30);
    chk(got_data.size() == 1, "midrst_no_extra", 32'(got_data.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000 time units");
    $fatal(1);
  end

endmodule
